// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - clocked stimulus/capture sweep for a 3-input combinational block
//
// Purpose: drives {a,b,c} through 000..111 and holds each vector for HOLD_CYCLES
// clocks. It samples o at the end of each hold window and builds an 8-bit truth
// table, then compares that table against exp_table.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   start        request a sweep (sampled only while idle)
//   o            output of the block under sweep
//   exp_table    expected truth table, bit i = expected o for vector i
//   a, b, c      stimulus vector (a is MSB)
//   busy         sweep in progress
//   done         one-cycle pulse when a sweep completes
//   truth_table  captured truth table, bit i = sampled o for vector i
//   pass         truth_table == exp_table, valid from done until next start

module truth_table_sweeper #(
   parameter int HOLD_CYCLES = 2,
   parameter int HOLD_W      = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       o,
   input  logic [7:0] exp_table,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       busy,
   output logic       done,
   output logic [7:0] truth_table,
   output logic       pass
);

   typedef enum logic {IDLE, SWEEP} state_t;

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

   state_t            state;
   state_t            state_next;
   logic [2:0]        idx;
   logic [HOLD_W-1:0] hold_cnt;
   logic              hold_end;
   logic              last_vec;

   assign hold_end = (hold_cnt == HOLD_LAST);
   assign last_vec = (idx == 3'd7);

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = SWEEP;
         SWEEP:   if (hold_end && last_vec) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs derived from registers only; idx returns to 0 when a sweep ends,
   // so it doubles as the stimulus vector and reads 000 while idle.
   always_comb begin
      busy      = (state == SWEEP);
      {a, b, c} = idx;
   end

   // Datapath: hold counter, vector index, capture and compare
   always_ff @(posedge clk) begin
      if (rst) begin
         idx         <= 3'd0;
         hold_cnt    <= '0;
         truth_table <= 8'h00;
         done        <= 1'b0;
         pass        <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  idx         <= 3'd0;
                  hold_cnt    <= '0;
                  truth_table <= 8'h00;
                  pass        <= 1'b0;
               end
            end
            SWEEP: begin
               if (!hold_end) begin
                  hold_cnt <= hold_cnt + HOLD_W'(1);
               end else begin
                  hold_cnt         <= '0;
                  truth_table[idx] <= o;
                  if (last_vec) begin
                     idx  <= 3'd0;
                     done <= 1'b1;
                     // Last bit is still in flight this edge, so compare with o spliced in.
                     pass <= ({o, truth_table[6:0]} == exp_table);
                  end else begin
                     idx <= idx + 3'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Upstream stimulus and capture stage for the 3-input combinational `sample` block.
- Steps `{a,b,c}` through 000..111 in order and holds each vector for a programmable number of clock cycles.
- Samples the block's output `o` at the end of each hold window and assembles an 8-bit truth table.
- Compares the truth table against an expected table and reports pass/fail, replacing free-running `#delay` stimulus with a clocked, self-checking sweep.

Parameters:
- HOLD_CYCLES, 2: cycles each input vector is driven before `o` is sampled. Legal range 1..255.
- HOLD_W, 8: width of the internal hold counter. Must satisfy HOLD_CYCLES <= 2^HOLD_W.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a sweep; sampled only while idle.
- o  input  1  output of the combinational block under sweep.
- exp_table  input  8  expected truth table, bit i = expected `o` for `{a,b,c}` = i. Must be stable from start until done.
- a  output  1  stimulus MSB.
- b  output  1  stimulus middle bit.
- c  output  1  stimulus LSB.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when the sweep completes.
- table  output  8  captured truth table, bit i = sampled `o` for vector i. Held after done.
- pass  output  1  (table == exp_table), valid from done, held until next start.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset (rst=1 at a rising edge): state=IDLE; a=b=c=0; busy=0; done=0; table=8'h00; pass=0; idx=0; hold_cnt=0. Reset wins over every other event, including mid-sweep. An aborted sweep produces no done pulse.
- All outputs are registered; there is no combinational path from `o` or `start` to any output.
- States: IDLE, SWEEP.
- IDLE:
  - busy=0; a, b, c held at 000.
  - If start=1 at edge k: state->SWEEP, busy=1, idx=0, `{a,b,c}`=000, hold_cnt=0, table=8'h00, pass=0.
- SWEEP, each edge:
  - If hold_cnt != HOLD_CYCLES-1: hold_cnt++.
  - Else: table[idx] <= o (sampled at this edge) and hold_cnt=0.
    - If idx < 7: idx++ and `{a,b,c}` <= idx+1.
    - If idx == 7: state->IDLE, busy=0, done=1, `{a,b,c}`=000, pass <= (`{o, table[6:0]}` == exp_table).
- Timing:
  - Vector i is driven during cycles k+i*H .. k+(i+1)*H-1, where H=HOLD_CYCLES.
  - `o` for vector i is sampled at edge k+(i+1)*H.
  - done rises at edge k+8H and falls at edge k+8H+1.
  - Total sweep = 8H cycles.
- HOLD_CYCLES=1: a new vector every cycle; `o` is sampled one cycle after its vector is applied.
- start while busy: ignored; no restart and no effect on idx, table or timing.
- start high on the same cycle done pulses (state already IDLE at the next edge): accepted at the next edge, so back-to-back sweeps are allowed. table is cleared when the new sweep starts.
- start held high continuously: continuous back-to-back sweeps, each producing one done pulse.
- idx is 3 bits and never wraps within a sweep; termination is on idx==7.
- table bits not yet captured read 0 while busy.

Test Plan:
1. Reset then idle: rst high 2 cycles, start=0 for 10 cycles -> a,b,c=000, busy=0, done=0, table=00, pass=0 throughout.
2. AND3 block, HOLD_CYCLES=2, exp_table=8'h80, start pulsed at edge 0 -> `{a,b,c}` increments every 2 cycles from 000 to 111; done pulses at edge 16; table=8'h80, pass=1.
3. XOR3 block, HOLD_CYCLES=1, exp_table=8'h96 -> done at edge 8, table=8'h96, pass=1. Repeat with exp_table=8'hE8 (majority) -> table=8'h96, pass=0.
4. Start ignored mid-sweep: majority block, H=2, start re-pulsed at edges 5 and 9 -> single done at edge 16, table=8'hE8, vector timing unchanged.
5. Reset mid-sweep: rst at edge 7 of an H=2 sweep -> at edge 7 a,b,c=000, busy=0, table=00, no done pulse. A fresh start then completes normally with a correct table.
6. Back-to-back: start held high, H=1, AND3 -> done pulses at edges 8 and 17; table=8'h80 after each; table reads 00 at edge 9.
